// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack, hands words to the decoder over valid/ready.
// Optional FETCH_PERF_EN adds instr_count and wait_cycles performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [25:0] addr26,
  input  logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] wait_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      state, state_next;
  logic        transfer;
  logic        consume;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign transfer   = imem_req && imem_ack;
  assign consume    = instr_valid && instr_ready;
  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Jump outranks branch when the decoder flags both.
  always_comb begin
    next_pc = pc_plus4;
    if (is_jump)
      next_pc = {pc_plus4[31:28], addr26, 2'b00};
    else if (is_branch && branch_taken)
      next_pc = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ:  if (transfer) state_next = S_HOLD;
      S_HOLD: if (consume)  state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instruction <= '0;
    end else begin
      if (transfer) instruction <= imem_rdata;
      if (consume)  pc          <= next_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      wait_cycles <= '0;
    end else begin
      if (consume)                       instr_count <= instr_count + 32'd1;
      if ((state == S_REQ) && !imem_ack) wait_cycles <= wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 32'h1000_0000) share all inputs.
// Perf counter checks are compiled only when FETCH_PERF_EN is defined.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        is_jump, is_branch, branch_taken;
  logic [25:0] addr26;
  logic [15:0] imm16;

  logic        req_m, valid_m, req_h, valid_h;
  logic [31:0] addr_m, instr_m, pc_m, pc4_m;
  logic [31:0] addr_h, instr_h, pc_h, pc4_h;
`ifdef FETCH_PERF_EN
  logic [31:0] icnt_m, wcnt_m, icnt_h, wcnt_h;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] m_pc, h_pc, last_word;
  int unsigned exp_instr, exp_wait;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(req_m), .imem_addr(addr_m), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instr_m), .instr_valid(valid_m), .instr_ready(instr_ready),
    .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken), .addr26(addr26),
    .imm16(imm16), .pc(pc_m), .pc_plus4(pc4_m)
`ifdef FETCH_PERF_EN
    , .instr_count(icnt_m), .wait_cycles(wcnt_m)
`endif
  );

  fetch_unit #(.RESET_PC(32'h1000_0000)) dut_hi (
    .clk(clk), .reset(reset), .imem_req(req_h), .imem_addr(addr_h), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instr_h), .instr_valid(valid_h), .instr_ready(instr_ready),
    .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken), .addr26(addr26),
    .imm16(imm16), .pc(pc_h), .pc_plus4(pc4_h)
`ifdef FETCH_PERF_EN
    , .instr_count(icnt_h), .wait_cycles(wcnt_h)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_EN
    check("instr_count", icnt_m, exp_instr);
    check("wait_cycles", wcnt_m, exp_wait);
`endif
  endtask

  // Starts in S_REQ; holds ack low for 'delay' cycles, then transfers 'word'.
  task automatic fetch(input logic [31:0] word, input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_0000 | i;
      check("wait_req", {31'b0, req_m}, 32'd1);
      check("wait_addr", addr_m, m_pc);
      check("wait_valid", {31'b0, valid_m}, 32'd0);
      tick();
      exp_wait++;
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    check("xfer_req", {31'b0, req_m}, 32'd1);
    check("xfer_addr", addr_m, m_pc);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    last_word  = word;
    check("hold_valid", {31'b0, valid_m}, 32'd1);
    check("hold_instr", instr_m, word);
    check("hold_req", {31'b0, req_m}, 32'd0);
    check("hold_pc", pc_m, m_pc);
    check_perf();
  endtask

  // Starts in S_HOLD; stalls 'hold' cycles, then consumes with the given decoder fields.
  task automatic consume(input logic j, input logic b, input logic t, input logic [25:0] a,
                         input logic [15:0] im, input logic [31:0] m_exp, input logic [31:0] h_exp,
                         input int unsigned hold);
    for (int unsigned i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      is_jump = 1'b1; is_branch = 1'b1; branch_taken = 1'b1;
      addr26 = 26'h3FF_FFFF; imm16 = 16'h1234;
      tick();
      check("stall_valid", {31'b0, valid_m}, 32'd1);
      check("stall_instr", instr_m, last_word);
      check("stall_pc", pc_m, m_pc);
      check("stall_req", {31'b0, req_m}, 32'd0);
    end
    instr_ready = 1'b1;
    is_jump = j; is_branch = b; branch_taken = t; addr26 = a; imm16 = im;
    tick();
    instr_ready = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; addr26 = '0; imm16 = '0;
    exp_instr++;
    m_pc = m_exp;
    h_pc = h_exp;
    check("next_valid", {31'b0, valid_m}, 32'd0);
    check("next_req", {31'b0, req_m}, 32'd1);
    check("next_addr", addr_m, m_exp);
    check("next_addr_hi", addr_h, h_exp);
    check("next_pc4", pc4_m, m_exp + 32'd4);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; addr26 = '0; imm16 = '0;
    exp_instr = 0; exp_wait = 0; m_pc = 32'h0; h_pc = 32'h1000_0000; last_word = '0;
    tick();
    tick();
    check("rst_req", {31'b0, req_m}, 32'd0);
    check("rst_valid", {31'b0, valid_m}, 32'd0);
    check("rst_instr", instr_m, 32'd0);
    check("rst_pc", pc_m, 32'd0);
    check("rst_pc_hi", pc_h, 32'h1000_0000);
    check("rst_pc4", pc4_m, 32'd4);
    check_perf();

    reset = 1'b0;
    check("idle_req", {31'b0, req_m}, 32'd0);
    tick();
    check("first_req", {31'b0, req_m}, 32'd1);
    check("first_addr", addr_m, 32'd0);

    fetch(32'h2008_0005, 0);
    consume(0, 0, 0, 26'h0, 16'h0, 32'h4, 32'h1000_0004, 0);
    fetch(32'h1111_0001, 3);
    consume(0, 1, 1, 26'h0, 16'hFFFE, 32'h0, 32'h1000_0000, 0);
    fetch(32'h1111_0002, 0);
    consume(1, 0, 0, 26'h040, 16'h0, 32'h100, 32'h1000_0100, 0);
    fetch(32'h1111_0003, 0);
    consume(0, 1, 1, 26'h0, 16'hFFBF, 32'h0, 32'h1000_0000, 0);
    fetch(32'h1111_0004, 2);
    consume(1, 1, 1, 26'h040, 16'h0010, 32'h100, 32'h1000_0100, 0);
    fetch(32'h1111_0005, 0);
    consume(1, 0, 0, 26'h004, 16'h0, 32'h10, 32'h1000_0010, 0);
    fetch(32'h1111_0006, 0);
    consume(0, 1, 1, 26'h0, 16'hFFFE, 32'hC, 32'h1000_000C, 0);
    fetch(32'h1111_0007, 1);
    consume(0, 0, 0, 26'h0, 16'h0, 32'h10, 32'h1000_0010, 5);
    tick();
    exp_wait++;
    check("one_consume_pc", pc_m, 32'h10);
    check("one_consume_req", {31'b0, req_m}, 32'd1);
    fetch(32'h1111_0008, 0);
    consume(0, 1, 0, 26'h0, 16'hFFFE, 32'h14, 32'h1000_0014, 0);
    fetch(32'h1111_0009, 0);
    consume(1, 0, 0, 26'h0, 16'h0, 32'h0, 32'h1000_0000, 0);
    fetch(32'h1111_000A, 0);
    consume(0, 1, 1, 26'h0, 16'hFFFE, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 0);
    fetch(32'h1111_000B, 0);
    consume(0, 0, 0, 26'h0, 16'h0, 32'h0, 32'h1000_0000, 0);
    fetch(32'h1111_000C, 0);
    consume(0, 0, 1, 26'h0, 16'h0100, 32'h4, 32'h1000_0004, 0);
    check_perf();

    // Reset in S_REQ with a simultaneous ack: the ack must be discarded.
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    exp_instr = 0; exp_wait = 0; m_pc = 32'h0; h_pc = 32'h1000_0000;
    check("rreq_req", {31'b0, req_m}, 32'd0);
    check("rreq_valid", {31'b0, valid_m}, 32'd0);
    check("rreq_instr", instr_m, 32'd0);
    check("rreq_pc", pc_m, 32'd0);
    check_perf();
    tick();
    check("rreq_rel_req", {31'b0, req_m}, 32'd1);
    check("rreq_rel_addr", addr_m, 32'd0);

    fetch(32'h2222_0001, 0);
    consume(1, 0, 0, 26'h010, 16'h0, 32'h40, 32'h1000_0040, 0);
    fetch(32'h2222_0002, 0);

    // Reset in S_HOLD at pc=0x40: the held word is dropped.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_instr = 0; exp_wait = 0; m_pc = 32'h0; h_pc = 32'h1000_0000;
    check("rhold_valid", {31'b0, valid_m}, 32'd0);
    check("rhold_pc", pc_m, 32'd0);
    check("rhold_pc_hi", pc_h, 32'h1000_0000);
    check("rhold_req", {31'b0, req_m}, 32'd0);
    check_perf();
    tick();
    check("rhold_rel_req", {31'b0, req_m}, 32'd1);
    check("rhold_rel_addr", addr_m, 32'd0);
    check("rhold_rel_valid", {31'b0, valid_m}, 32'd0);
    fetch(32'h2222_0003, 0);
    consume(0, 0, 0, 26'h0, 16'h0, 32'h4, 32'h1000_0004, 0);
    check_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the single-cycle MIPS datapath.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched 32-bit word to the control decoder with a valid/ready handshake.
- Takes the decoder's is_jump, is_branch, addr26 and imm16, plus the datapath's branch_taken, to compute the next PC. This closes the loop that drives the decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  byte address of the request; always equals pc.
- imem_ack  input  1  memory accepted the request and imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word returned by memory.
- instruction  output  32  fetched word presented to the decoder.
- instr_valid  output  1  instruction is valid.
- instr_ready  input  1  decoder/datapath consumes instruction this cycle.
- is_jump  input  1  decoder: current instruction is a jump.
- is_branch  input  1  decoder: current instruction is a branch.
- branch_taken  input  1  datapath: branch condition true.
- addr26  input  26  decoder jump target field.
- imm16  input  16  decoder branch offset field.
- pc  output  32  address of the current or pending instruction.
- pc_plus4  output  32  pc + 4 (combinational).

Behaviour:
- States: S_IDLE, S_REQ, S_HOLD.
- Reset (sync): state=S_IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=0. Reset wins over every other event in the same cycle.
- S_IDLE: no outputs asserted; unconditionally goes to S_REQ next cycle. imem_req first rises 1 cycle after reset deasserts.
- S_REQ: imem_req=1 and imem_addr=pc, both held stable until a transfer.
  - Transfer = imem_req && imem_ack in the same cycle.
  - On transfer: instruction<=imem_rdata, instr_valid<=1, imem_req<=0, go to S_HOLD.
  - imem_ack while imem_req=0 is ignored.
  - Only one request is outstanding at a time.
- S_HOLD: instr_valid=1; instruction and pc are held stable until instr_ready.
  - Decoder inputs are sampled only in the cycle where instr_valid && instr_ready.
  - On consume: pc<=next_pc, instr_valid<=0, go to S_REQ, and imem_req asserts the following cycle. Minimum 2 cycles per instruction when memory acks immediately.
- next_pc priority:
  - is_jump=1: next_pc = {pc_plus4[31:28], addr26, 2'b00}.
  - else is_branch && branch_taken: next_pc = pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - else: next_pc = pc_plus4.
  - is_jump && is_branch together: jump wins.
- Arithmetic: 32-bit, wraps modulo 2^32. pc=32'hFFFF_FFFC with sequential flow goes to 32'h0000_0000. Negative branch offsets wrap the same way.
- is_jump, is_branch, branch_taken, addr26 and imm16 are don't-care outside the consume cycle.
- Reset mid-operation:
  - In S_REQ: imem_req drops next cycle; an ack in the reset cycle is discarded.
  - In S_HOLD: the held instruction is dropped and is never re-presented.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports instr_count[31:0] and wait_cycles[31:0], both reset to 0.
  - instr_count increments on each consume.
  - wait_cycles increments each S_REQ cycle with imem_ack=0.
  - Both wrap at 2^32.
- Undefined: neither port nor the counter logic exists. All other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory acks at once with 32'h2008_0005 -> imem_req high on cycle 1 with addr 0; instr_valid high cycle 2 with instruction 32'h2008_0005; with instr_ready=1, next request addr=4.
- Memory delays ack 3 cycles -> imem_req and imem_addr stay stable for all 3 wait cycles; instr_valid stays 0; with FETCH_PERF_EN, wait_cycles=3.
- Consume at pc=32'h0000_0010 with is_branch=1, branch_taken=1, imm16=16'hFFFE -> next imem_addr=32'h0000_000C. Same stimulus with branch_taken=0 -> next imem_addr=32'h0000_0014.
- Consume at pc=32'h1000_0000 with is_jump=1, addr26=26'h000_0040 -> next imem_addr=32'h1000_0100. Repeat with is_branch=1 and branch_taken=1 also set -> jump target still wins.
- Hold instr_ready=0 for 5 cycles in S_HOLD -> instruction, pc and instr_valid stay constant and imem_req stays 0; assert instr_ready -> exactly one consume occurs.
- Assert reset in S_HOLD at pc=32'h40 -> next cycle instr_valid=0 and pc=RESET_PC; first request after release is at RESET_PC.
